// File: rtl/edge_detector_mc.sv
// edge_detector_mc: multi-channel synchronising edge detector.
// Each channel synchronises its raw input and applies a persistence filter.
// It reports accepted level changes as one-cycle rise/fall pulses and keeps
// sticky, enable-gated pending flags that are OR-ed into a single interrupt.
module edge_detector_mc #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] signal_i,
   input  logic [WIDTH-1:0] rise_en_i,
   input  logic [WIDTH-1:0] fall_en_i,
   input  logic [WIDTH-1:0] clr_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rising_edge_o,
   output logic [WIDTH-1:0] falling_edge_o,
   output logic [WIDTH-1:0] pending_o,
   output logic             irq_o
);

   localparam int CW = $clog2(FILT_CNT + 1);
   // The counter value on the cycle in which the difference has persisted
   // FILT_CNT times, counting the current cycle.
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] level_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] pend_q;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: stage 0 captures the raw asynchronous inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= signal_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // A channel accepts its new level once the difference has lasted FILT_CNT cycles.
   always_comb begin
      accept = '0;
      for (int unsigned n = 0; n < WIDTH; n++) begin
         accept[n] = (s[n] != level_q[n]) && (cnt_q[n] == CNT_LAST);
      end
   end

   // Persistence counters: count while s differs from level, clear on agreement or acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < WIDTH; n++) begin
            cnt_q[n] <= '0;
         end
      end else begin
         for (int unsigned n = 0; n < WIDTH; n++) begin
            if ((s[n] == level_q[n]) || accept[n]) begin
               cnt_q[n] <= '0;
            end else begin
               cnt_q[n] <= cnt_q[n] + 1'b1;
            end
         end
      end
   end

   // Filtered level and edge pulses; the pulses coincide with the first cycle of the new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         level_q <= level_q ^ accept;
         rise_q  <= accept & ~level_q;
         fall_q  <= accept & level_q;
      end
   end

   // Sticky pending flags: a set from an enabled pulse overrides a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr_i) | (rise_q & rise_en_i) | (fall_q & fall_en_i);
      end
   end

   assign level_o        = level_q;
   assign rising_edge_o  = rise_q;
   assign falling_edge_o = fall_q;
   assign pending_o      = pend_q;
   assign irq_o          = |pend_q;

endmodule

// File: tb/tb_edge_detector_mc.sv
// tb_edge_detector_mc: directed test of edge_detector_mc with WIDTH=4,
// SYNC_STAGES=2, FILT_CNT=3 (five-edge input-to-level latency).
module tb_edge_detector_mc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] signal_i  = '0;
   logic [3:0] rise_en_i = '0;
   logic [3:0] fall_en_i = '0;
   logic [3:0] clr_i     = '0;
   logic [3:0] level_o;
   logic [3:0] rising_edge_o;
   logic [3:0] falling_edge_o;
   logic [3:0] pending_o;
   logic       irq_o;

   int checks = 0;
   int errors = 0;

   edge_detector_mc #(
      .WIDTH(4),
      .SYNC_STAGES(2),
      .FILT_CNT(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .signal_i(signal_i),
      .rise_en_i(rise_en_i),
      .fall_en_i(fall_en_i),
      .clr_i(clr_i),
      .level_o(level_o),
      .rising_edge_o(rising_edge_o),
      .falling_edge_o(falling_edge_o),
      .pending_o(pending_o),
      .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"}, 32'(level_o), 32'h0);
      chk({tag, "_rise"},  32'(rising_edge_o), 32'h0);
      chk({tag, "_fall"},  32'(falling_edge_o), 32'h0);
      chk({tag, "_pend"},  32'(pending_o), 32'h0);
      chk({tag, "_irq"},   32'(irq_o), 32'h0);
   endtask

   initial begin
      // Reset asserted before any clock edge.
      #2;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Channel 0 rises and is held: level and pulse appear on the 5th edge.
      signal_i = 4'b0001;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         chk("ch0_rise_wait_level", 32'(level_o), 32'h0);
         chk("ch0_rise_wait_pulse", 32'(rising_edge_o), 32'h0);
      end
      step(1);
      chk("ch0_rise_level", 32'(level_o), 32'h1);
      chk("ch0_rise_pulse", 32'(rising_edge_o), 32'h1);
      chk("ch0_rise_nofall", 32'(falling_edge_o), 32'h0);
      step(1);
      chk("ch0_rise_pulse_end", 32'(rising_edge_o), 32'h0);
      chk("ch0_rise_level_hold", 32'(level_o), 32'h1);
      chk("ch0_rise_no_pend", 32'(pending_o), 32'h0);

      // Channel 1 glitch of two cycles is filtered out.
      signal_i = 4'b0011;
      step(2);
      signal_i = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("ch1_glitch_level", 32'(level_o), 32'h1);
         chk("ch1_glitch_rise", 32'(rising_edge_o), 32'h0);
         chk("ch1_glitch_fall", 32'(falling_edge_o), 32'h0);
      end
      chk("ch1_glitch_pend", 32'(pending_o), 32'h0);

      // Bring ch0 low with falls disabled, then rise with rise enabled.
      signal_i = 4'b0000;
      step(5);
      chk("ch0_fall_pulse", 32'(falling_edge_o), 32'h1);
      chk("ch0_fall_level", 32'(level_o), 32'h0);
      step(1);
      chk("ch0_fall_no_pend", 32'(pending_o), 32'h0);
      rise_en_i = 4'b0001;
      signal_i  = 4'b0001;
      step(5);
      chk("ch0_en_pulse", 32'(rising_edge_o), 32'h1);
      chk("ch0_en_pend_before", 32'(pending_o), 32'h0);
      chk("ch0_en_irq_before", 32'(irq_o), 32'h0);
      step(1);
      chk("ch0_en_pend_set", 32'(pending_o), 32'h1);
      chk("ch0_en_irq_set", 32'(irq_o), 32'h1);
      step(3);
      chk("ch0_pend_sticky", 32'(pending_o), 32'h1);
      clr_i = 4'b0001;
      step(1);
      clr_i = 4'b0000;
      chk("ch0_clr_pend", 32'(pending_o), 32'h0);
      chk("ch0_clr_irq", 32'(irq_o), 32'h0);

      // Clear coinciding with set: set wins.
      signal_i = 4'b0000;
      step(6);
      chk("ch0_fall2_no_pend", 32'(pending_o), 32'h0);
      signal_i = 4'b0001;
      step(5);
      chk("ch0_coinc_pulse", 32'(rising_edge_o), 32'h1);
      clr_i = 4'b0001;
      step(1);
      clr_i = 4'b0000;
      chk("ch0_coinc_pend", 32'(pending_o), 32'h1);
      chk("ch0_coinc_irq", 32'(irq_o), 32'h1);
      step(1);
      chk("ch0_coinc_pend_hold", 32'(pending_o), 32'h1);
      clr_i = 4'b0001;
      step(1);
      clr_i = 4'b0000;
      chk("ch0_coinc_cleared", 32'(pending_o), 32'h0);

      // Channel 2 rises then falls with fall disabled: single fall pulse, no pending.
      signal_i = 4'b0101;
      step(5);
      chk("ch2_rise_pulse", 32'(rising_edge_o), 32'h4);
      chk("ch2_rise_level", 32'(level_o), 32'h5);
      step(1);
      chk("ch2_rise_no_pend", 32'(pending_o), 32'h0);
      signal_i = 4'b0001;
      step(5);
      chk("ch2_fall_pulse", 32'(falling_edge_o), 32'h4);
      chk("ch2_fall_norise", 32'(rising_edge_o), 32'h0);
      chk("ch2_fall_level", 32'(level_o), 32'h1);
      step(1);
      chk("ch2_fall_pulse_end", 32'(falling_edge_o), 32'h0);
      chk("ch2_fall_no_pend", 32'(pending_o), 32'h0);

      // Reset mid-count, then all four channels rise together.
      signal_i  = 4'hF;
      rise_en_i = 4'hF;
      step(3);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_async");
      step(1);
      chk_all_zero("rst_held");
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         chk("rst_rel_wait_level", 32'(level_o), 32'h0);
         chk("rst_rel_wait_pulse", 32'(rising_edge_o), 32'h0);
      end
      step(1);
      chk("rst_rel_pulse", 32'(rising_edge_o), 32'hF);
      chk("rst_rel_level", 32'(level_o), 32'hF);
      step(1);
      chk("rst_rel_pulse_end", 32'(rising_edge_o), 32'h0);
      chk("rst_rel_pend", 32'(pending_o), 32'hF);
      chk("rst_rel_irq", 32'(irq_o), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
